// File: rtl/regfile_seq_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_seq_if
// Brief   : Bundle between the sequencer, fetch/PC, register file and execute.
// Rev     : 1.0
// ============================================================================
interface regfile_seq_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        rf_active;
    logic        rf_w_en;
    logic        rf_reg_dst;
    logic [31:0] rf_instruction;
    logic [31:0] rf_write_data;
    logic [31:0] rf_read_data1;
    logic [31:0] rf_read_data2;
    logic        op_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        result_valid;
    logic [31:0] result;
    logic        instr_done;
    logic        err;

    // Sequencer side
    modport master (
        input  instr_valid, instr, rf_read_data1, rf_read_data2, result_valid, result,
        output instr_ready, rf_active, rf_w_en, rf_reg_dst, rf_instruction, rf_write_data,
               op_valid, op_a, op_b, instr_done, err
    );

    // Fetch / register file / execute side
    modport slave (
        output instr_valid, instr, rf_read_data1, rf_read_data2, result_valid, result,
        input  instr_ready, rf_active, rf_w_en, rf_reg_dst, rf_instruction, rf_write_data,
               op_valid, op_a, op_b, instr_done, err
    );
endinterface
`default_nettype wire

// File: rtl/regfile_seq.sv
`default_nettype none
// ============================================================================
// Module  : regfile_seq
// Brief   : Multi-cycle read / execute / write-back sequencer for the register file.
// Rev     : 1.0
// ============================================================================
module regfile_seq #(
    parameter int TIMEOUT = 255
) (
    input  wire logic     clk,
    input  wire logic     reset,
    regfile_seq_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CAPT  = 3'd2,
        S_EXEC  = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [15:0] c_timeout_last = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_instr_ready;
    logic        r_rf_active;
    logic        r_rf_w_en;
    logic        r_op_valid;
    logic        r_instr_done;
    logic        r_err;
    logic        r_reg_dst;
    logic        r_do_write;
    logic [31:0] r_instr;
    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [31:0] r_wdata;
    logic [15:0] r_cnt;

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    logic        w_is_rtype;
    logic        w_is_itype;
    logic [4:0]  w_dest;
    logic        w_writes;

    // Write-class decode of the word offered by fetch; used only at accept
    assign w_opcode   = bus.instr[31:26];
    assign w_funct    = bus.instr[5:0];
    assign w_is_rtype = (w_opcode == 6'h00) && (w_funct != 6'h08);
    assign w_is_itype = ((w_opcode >= 6'h08) && (w_opcode <= 6'h0F)) ||
                        ((w_opcode >= 6'h20) && (w_opcode <= 6'h25));
    assign w_dest     = w_is_rtype ? bus.instr[15:11] : bus.instr[20:16];
    assign w_writes   = (w_is_rtype || w_is_itype) && (w_dest != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_instr_ready <= 1'b1;
            r_rf_active   <= 1'b0;
            r_rf_w_en     <= 1'b0;
            r_op_valid    <= 1'b0;
            r_instr_done  <= 1'b0;
            r_err         <= 1'b0;
            r_reg_dst     <= 1'b0;
            r_do_write    <= 1'b0;
            r_instr       <= 32'd0;
            r_op_a        <= 32'd0;
            r_op_b        <= 32'd0;
            r_wdata       <= 32'd0;
            r_cnt         <= 16'd0;
        end else begin
            r_rf_active  <= 1'b0;
            r_rf_w_en    <= 1'b0;
            r_instr_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        r_instr       <= bus.instr;
                        r_reg_dst     <= w_is_rtype;
                        r_do_write    <= w_writes;
                        r_instr_ready <= 1'b0;
                        r_rf_active   <= 1'b1;
                        r_state       <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    // Register file data is valid one cycle after the read strobe
                    r_op_a     <= bus.rf_read_data1;
                    r_op_b     <= bus.rf_read_data2;
                    r_cnt      <= 16'd0;
                    r_op_valid <= 1'b1;
                    r_state    <= S_EXEC;
                end
                S_EXEC: begin
                    if (bus.result_valid) begin
                        r_wdata    <= bus.result;
                        r_op_valid <= 1'b0;
                        if (r_do_write) begin
                            r_rf_w_en <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_instr_done <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end else if (r_cnt == c_timeout_last) begin
                        r_err        <= 1'b1;
                        r_op_valid   <= 1'b0;
                        r_instr_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_WRITE: begin
                    r_instr_done <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_instr_ready <= 1'b1;
                    r_op_valid    <= 1'b0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready    = r_instr_ready;
    assign bus.rf_active      = r_rf_active;
    assign bus.rf_w_en        = r_rf_w_en;
    assign bus.rf_reg_dst     = r_reg_dst;
    assign bus.rf_instruction = r_instr;
    assign bus.rf_write_data  = r_wdata;
    assign bus.op_valid       = r_op_valid;
    assign bus.op_a           = r_op_a;
    assign bus.op_b           = r_op_b;
    assign bus.instr_done     = r_instr_done;
    assign bus.err            = r_err;
endmodule
`default_nettype wire

// File: tb/tb_regfile_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_seq
// Brief   : Self-checking bench for regfile_seq with a write-back scoreboard.
// Rev     : 1.0
// ============================================================================
module tb_regfile_seq;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        dst;
        logic [31:0] data;
    } sb_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   done_cnt;
    int   read_cnt;
    sb_t  sb[$];

    regfile_seq_if bus ();

    regfile_seq #(.TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-back monitor: every rf_w_en pulse must match the oldest expected write
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rf_w_en) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_write: rf_w_en=1 data=%h, required no write", bus.rf_write_data);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    if (bus.rf_write_data !== e.data || bus.rf_reg_dst !== e.dst || bus.rf_active !== 1'b0) begin
                        n_errors++;
                        $display("FAIL write_back: data=%h dst=%b rf_active=%b, required data=%h dst=%b rf_active=0",
                                 bus.rf_write_data, bus.rf_reg_dst, bus.rf_active, e.data, e.dst);
                    end
                end
            end
            if (bus.instr_done) done_cnt++;
            if (bus.rf_active)  read_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.instr_ready !== 1'b1 || bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_ready_err: ready=%b err=%b, required 1/0", bus.instr_ready, bus.err);
        end
        n_checks++;
        if ({bus.rf_active, bus.rf_w_en, bus.op_valid, bus.instr_done, bus.rf_reg_dst} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_strobes: %b, required 00000",
                     {bus.rf_active, bus.rf_w_en, bus.op_valid, bus.instr_done, bus.rf_reg_dst});
        end
        n_checks++;
        if ({bus.rf_instruction, bus.op_a, bus.op_b, bus.rf_write_data} !== 128'd0) begin
            n_errors++;
            $display("FAIL reset_data: instr=%h a=%h b=%h wd=%h, required all 0",
                     bus.rf_instruction, bus.op_a, bus.op_b, bus.rf_write_data);
        end
        reset = 1'b0;
        tick();
    endtask

    // Issue one instruction from IDLE; result arrives in EXEC cycle 'lat'
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] res, input int lat, input bit wr, input bit dst);
        int n_opv;
        if (wr) sb.push_back('{dst, res});
        n_checks++;
        if (bus.instr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_before_accept: %b, required 1", bus.instr_ready);
        end
        bus.instr_valid   = 1'b1;
        bus.instr         = ins;
        bus.rf_read_data1 = d1;
        bus.rf_read_data2 = d2;
        tick();                                   // E0: accept, now READ
        bus.instr_valid = 1'b0;
        bus.instr       = 32'hFFFF_FFFF;
        n_checks++;
        if (bus.rf_active !== 1'b1 || bus.instr_ready !== 1'b0 || bus.rf_instruction !== ins || bus.rf_reg_dst !== dst) begin
            n_errors++;
            $display("FAIL read_phase: act=%b rdy=%b instr=%h dst=%b, required 1/0/%h/%b",
                     bus.rf_active, bus.instr_ready, bus.rf_instruction, bus.rf_reg_dst, ins, dst);
        end
        tick();                                   // E1: CAPT
        n_checks++;
        if (bus.rf_active !== 1'b0 || bus.op_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL capt_phase: act=%b opv=%b, required 0/0", bus.rf_active, bus.op_valid);
        end
        tick();                                   // E2: EXEC
        bus.rf_read_data1 = ~d1;
        bus.rf_read_data2 = ~d2;
        n_checks++;
        if (bus.op_a !== d1 || bus.op_b !== d2) begin
            n_errors++;
            $display("FAIL operands: a=%h b=%h, required %h %h", bus.op_a, bus.op_b, d1, d2);
        end
        n_opv = 0;
        for (int k = 1; k <= lat; k++) begin
            if (bus.op_valid === 1'b1) n_opv++;
            if (k == lat) begin
                bus.result_valid = 1'b1;
                bus.result       = res;
            end
            tick();
            bus.result_valid = 1'b0;
            bus.result       = 32'h0;
        end
        n_checks++;
        if (n_opv != lat || bus.op_valid !== 1'b0 || bus.op_a !== d1 || bus.op_b !== d2) begin
            n_errors++;
            $display("FAIL exec_hold: op_valid cycles=%0d now=%b a=%h b=%h, required %0d/0/%h/%h",
                     n_opv, bus.op_valid, bus.op_a, bus.op_b, lat, d1, d2);
        end
        if (wr) begin
            n_checks++;
            if (bus.rf_w_en !== 1'b1 || bus.instr_done !== 1'b0) begin
                n_errors++;
                $display("FAIL write_cycle: w_en=%b done=%b, required 1/0", bus.rf_w_en, bus.instr_done);
            end
            tick();
        end
        n_checks++;
        if (bus.instr_done !== 1'b1 || bus.rf_w_en !== 1'b0) begin
            n_errors++;
            $display("FAIL done_cycle: done=%b w_en=%b, required 1/0", bus.instr_done, bus.rf_w_en);
        end
        tick();
        n_checks++;
        if (bus.instr_done !== 1'b0 || bus.instr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL back_to_idle: done=%b rdy=%b, required 0/1", bus.instr_done, bus.instr_ready);
        end
    endtask

    task automatic test_rtype();
        run_instr(32'h0022_1820, 32'd5, 32'd9, 32'd14, 1, 1'b1, 1'b1);
    endtask

    task automatic test_itype();
        run_instr(32'h2085_0007, 32'h100, 32'h200, 32'h10, 3, 1'b1, 1'b0);
    endtask

    task automatic test_nowrite();
        int d0;
        d0 = done_cnt;
        run_instr(32'hAC22_0000, 32'h1000, 32'h2, 32'h55, 1, 1'b0, 1'b0);
        run_instr(32'h0022_0020, 32'd5, 32'd9, 32'd14, 2, 1'b0, 1'b1);
        n_checks++;
        if (done_cnt - d0 != 2) begin
            n_errors++;
            $display("FAIL nowrite_done_count: %0d, required 2", done_cnt - d0);
        end
    endtask

    task automatic test_timeout();
        int n, n_opv;
        bus.instr_valid = 1'b1;
        bus.instr       = 32'h0022_1820;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();                                   // first EXEC cycle
        n = 0;
        n_opv = 0;
        while (bus.instr_done !== 1'b1 && n < 20) begin
            if (bus.op_valid === 1'b1) n_opv++;
            tick();
            n++;
        end
        n_checks++;
        if (bus.instr_done !== 1'b1 || n_opv != TIMEOUT || bus.err !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout: done=%b exec cycles=%0d err=%b, required 1/%0d/1",
                     bus.instr_done, n_opv, bus.err, TIMEOUT);
        end
        tick();
        run_instr(32'h0022_1820, 32'd1, 32'd2, 32'd3, 2, 1'b1, 1'b1);
        n_checks++;
        if (bus.err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_sticky: %b, required 1", bus.err);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bus.instr_valid   = 1'b1;
        bus.instr         = 32'h0022_1820;
        bus.rf_read_data1 = 32'hAAAA;
        bus.rf_read_data2 = 32'hBBBB;
        tick();
        bus.instr_valid = 1'b0;
        tick();
        tick();
        tick();                                   // second EXEC cycle
        d0 = done_cnt;
        reset = 1'b1;
        bus.result_valid = 1'b1;
        bus.result       = 32'h77;
        #1;
        n_checks++;
        if ({bus.instr_ready, bus.rf_active, bus.rf_w_en, bus.op_valid, bus.instr_done, bus.err, bus.rf_reg_dst} !== 7'b1000000 ||
            {bus.rf_instruction, bus.op_a, bus.op_b, bus.rf_write_data} !== 128'd0) begin
            n_errors++;
            $display("FAIL reset_mid_exec: ctl=%b a=%h wd=%h instr=%h, required 1000000 and zero data",
                     {bus.instr_ready, bus.rf_active, bus.rf_w_en, bus.op_valid, bus.instr_done, bus.err, bus.rf_reg_dst},
                     bus.op_a, bus.rf_write_data, bus.rf_instruction);
        end
        tick();
        tick();
        reset = 1'b0;
        bus.result_valid = 1'b0;
        tick();
        tick();
        n_checks++;
        if (done_cnt != d0 || bus.instr_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_drop: done pulses=%0d rdy=%b, required 0/1", done_cnt - d0, bus.instr_ready);
        end
        run_instr(32'h0022_1820, 32'd5, 32'd9, 32'd14, 1, 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3];
        logic [31:0] res [3];
        bit          dst [3];
        int          r0, d0, n;
        ins[0] = 32'h0022_1820; res[0] = 32'h111; dst[0] = 1'b1;
        ins[1] = 32'h0022_2020; res[1] = 32'h222; dst[1] = 1'b1;
        ins[2] = 32'h2085_0007; res[2] = 32'h333; dst[2] = 1'b0;
        r0 = read_cnt;
        d0 = done_cnt;
        bus.rf_read_data1 = 32'd5;
        bus.rf_read_data2 = 32'd9;
        bus.instr_valid   = 1'b1;
        bus.instr         = ins[0];
        for (int i = 0; i < 3; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (bus.rf_active !== 1'b1 && n < 10);
            bus.result_valid = 1'b0;
            bus.result       = 32'h0;
            n_checks++;
            if (bus.rf_active !== 1'b1 || bus.rf_instruction !== ins[i] || (i > 0 && n != 2)) begin
                n_errors++;
                $display("FAIL b2b_accept%0d: act=%b instr=%h edges=%0d, required 1/%h/2", i,
                         bus.rf_active, bus.rf_instruction, n, ins[i]);
            end
            sb.push_back('{dst[i], res[i]});
            if (i < 2) bus.instr = ins[i+1];
            else       bus.instr_valid = 1'b0;
            tick();
            tick();                               // EXEC
            bus.result_valid = 1'b1;
            bus.result       = res[i];
            tick();
            bus.result_valid = 1'b0;
            n = 0;
            while (bus.instr_done !== 1'b1 && n < 10) begin
                tick();
                n++;
            end
            // Spurious result while in DONE and the following IDLE cycle
            bus.result_valid = 1'b1;
            bus.result       = 32'hBAD0_BAD0;
        end
        tick();
        tick();
        bus.result_valid = 1'b0;
        tick();
        n_checks++;
        if (read_cnt - r0 != 3 || done_cnt - d0 != 3 || bus.instr_ready !== 1'b1 || bus.rf_write_data !== res[2]) begin
            n_errors++;
            $display("FAIL b2b_counts: reads=%0d dones=%0d rdy=%b wd=%h, required 3/3/1/%h",
                     read_cnt - r0, done_cnt - d0, bus.instr_ready, bus.rf_write_data, res[2]);
        end
    endtask

    initial begin
        n_checks          = 0;
        n_errors          = 0;
        done_cnt          = 0;
        read_cnt          = 0;
        reset             = 1'b1;
        bus.instr_valid   = 1'b0;
        bus.instr         = 32'h0;
        bus.rf_read_data1 = 32'h0;
        bus.rf_read_data2 = 32'h0;
        bus.result_valid  = 1'b0;
        bus.result        = 32'h0;
        test_reset();
        test_rtype();
        test_itype();
        test_nowrite();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        tick();
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL pending_writes: %0d outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
